// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive framing controller. Synchronises the raw serial
//             line, qualifies the start bit at mid-bit, samples each data bit
//             at mid-bit on the oversampling tick, and checks the optional
//             parity bit and the stop bit. It drives the shift/load strobes
//             of the downstream receive shift register.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      : data bits per frame
//    OVERSAMPLE : baud_tick pulses per bit period (even, >= 4)
//    PARITY_EN  : 1 = frame carries one parity bit after the data bits
//    PARITY_ODD : 0 = even parity, 1 = odd parity
//  Ports
//    clk        : system clock, rising edge
//    rst_n      : asynchronous active-low reset
//    rx         : raw serial line (asynchronous, idles high)
//    baud_tick  : single-cycle pulse at OVERSAMPLE x baud rate
//    sh_en      : one-cycle enable strobe to the shift register
//    ld_sh      : with sh_en, 1 = load/transfer word, 0 = shift in rx_bit
//    rx_bit     : sampled data bit presented to the shift register
//    parity_err : parity mismatch on the last frame
//    frame_err  : stop bit sampled low on the last frame
//    rx_done    : one-cycle pulse when a frame ends with a good stop bit
//    busy       : high whenever the controller is not idle
// ============================================================================
module uart_rx_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic baud_tick,
    output logic sh_en,
    output logic ld_sh,
    output logic rx_bit,
    output logic parity_err,
    output logic frame_err,
    output logic rx_done,
    output logic busy
);

    localparam int unsigned c_TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned c_IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Tick index at which the start bit is re-checked (middle of the bit)
    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    // Tick index at which data/parity/stop bits are sampled (one full bit
    // after the previous sample point, so still mid-bit)
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(WIDTH - 1);
    localparam logic                c_ODD       = PARITY_ODD;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset looks like an idle line)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    logic                r_par_acc;
    logic                w_par_nxt;

    logic r_sh_en;
    logic w_sh_en_nxt;
    logic r_ld_sh;
    logic w_ld_sh_nxt;
    logic r_rx_bit;
    logic w_rx_bit_nxt;
    logic r_parity_err;
    logic w_parity_err_nxt;
    logic r_frame_err;
    logic w_frame_err_nxt;
    logic r_rx_done;
    logic w_rx_done_nxt;
    logic r_busy;

    // Sample strobes: the qualifying tick of the current bit period
    logic w_half_tick;
    logic w_full_tick;

    assign w_half_tick = baud_tick && (r_tick_cnt == c_TICK_HALF);
    assign w_full_tick = baud_tick && (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_bit_idx    <= '0;
            r_par_acc    <= 1'b0;
            r_sh_en      <= 1'b0;
            r_ld_sh      <= 1'b0;
            r_rx_bit     <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_done    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_bit_idx    <= w_idx_nxt;
            r_par_acc    <= w_par_nxt;
            r_sh_en      <= w_sh_en_nxt;
            r_ld_sh      <= w_ld_sh_nxt;
            r_rx_bit     <= w_rx_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_rx_done    <= w_rx_done_nxt;
            // Registered from the next state so busy tracks r_state exactly
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. All outputs are registered, so a
    // strobe decided on the qualifying baud_tick appears one clk later.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick_cnt;
        w_idx_nxt        = r_bit_idx;
        w_par_nxt        = r_par_acc;
        w_sh_en_nxt      = 1'b0;
        w_ld_sh_nxt      = 1'b0;
        w_rx_done_nxt    = 1'b0;
        w_rx_bit_nxt     = r_rx_bit;
        w_parity_err_nxt = r_parity_err;
        w_frame_err_nxt  = r_frame_err;

        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_tick_nxt  = '0;
                end
            end

            ST_START: begin
                if (w_half_tick) begin
                    w_tick_nxt = '0;
                    if (r_rx_s) begin
                        // Line back high by mid-bit: treat as a glitch
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Accepted start bit: error flags of the previous
                        // frame are released here and no earlier
                        w_state_nxt      = ST_DATA;
                        w_idx_nxt        = '0;
                        w_par_nxt        = 1'b0;
                        w_parity_err_nxt = 1'b0;
                        w_frame_err_nxt  = 1'b0;
                    end
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (w_full_tick) begin
                    w_tick_nxt   = '0;
                    w_rx_bit_nxt = r_rx_s;
                    w_sh_en_nxt  = 1'b1;
                    w_par_nxt    = r_par_acc ^ r_rx_s;
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end

            ST_PARITY: begin
                if (w_full_tick) begin
                    w_tick_nxt       = '0;
                    w_parity_err_nxt = PARITY_EN & (r_par_acc ^ r_rx_s ^ c_ODD);
                    w_state_nxt      = ST_STOP;
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (w_full_tick) begin
                    w_tick_nxt = '0;
                    if (r_rx_s) begin
                        w_sh_en_nxt   = 1'b1;
                        w_ld_sh_nxt   = 1'b1;
                        w_rx_done_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        // Low stop bit (possibly a break): wait for the line
                        // to recover so a held-low line cannot retrigger
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_WAIT_IDLE;
                    end
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_tick_nxt  = '0;
            end
        endcase
    end

    assign sh_en      = r_sh_en;
    assign ld_sh      = r_ld_sh;
    assign rx_bit     = r_rx_bit;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign rx_done    = r_rx_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl. Instance A uses even
//             parity, instance B has parity disabled. Frames are described
//             as data/parity/stop values; expected strobe sequences, spacing
//             and error flags are derived from those values.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    logic sh_en_a, ld_sh_a, rx_bit_a, perr_a, ferr_a, done_a, busy_a;
    logic sh_en_b, ld_sh_b, rx_bit_b, perr_b, ferr_b, done_b, busy_b;

    uart_rx_ctrl #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .baud_tick(baud_tick),
        .sh_en(sh_en_a), .ld_sh(ld_sh_a), .rx_bit(rx_bit_a),
        .parity_err(perr_a), .frame_err(ferr_a), .rx_done(done_a), .busy(busy_a)
    );

    uart_rx_ctrl #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .baud_tick(baud_tick),
        .sh_en(sh_en_b), .ld_sh(ld_sh_b), .rx_bit(rx_bit_b),
        .parity_err(perr_b), .frame_err(ferr_b), .rx_done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // ---------------- baud tick generator (period = tick_div clk) -------
    int tick_div = 1;
    initial begin : g_tick
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt >= tick_div - 1) begin
                baud_tick = 1'b1;
                cnt = 0;
            end else begin
                baud_tick = 1'b0;
                cnt++;
            end
        end
    end

    // ---------------- strobe monitor -----------------------------------
    typedef struct packed {
        logic        ld;
        logic        b;
        logic        done;
        logic        perr;
        logic        ferr;
        logic [31:0] cyc;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    logic [31:0] cyc = 0;
    int viol = 0;
    logic sh_prev_a = 1'b0;
    logic sh_prev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sh_en_a) q_a.push_back('{ld_sh_a, rx_bit_a, done_a, perr_a, ferr_a, cyc});
        if (sh_en_b) q_b.push_back('{ld_sh_b, rx_bit_b, done_b, perr_b, ferr_b, cyc});
        // ld_sh needs sh_en, rx_done coincides with ld_sh, strobes are 1 clk
        if ((ld_sh_a && !sh_en_a) || (done_a != ld_sh_a) || (sh_en_a && sh_prev_a)) viol++;
        if ((ld_sh_b && !sh_en_b) || (done_b != ld_sh_b) || (sh_en_b && sh_prev_b)) viol++;
        sh_prev_a = sh_en_a;
        sh_prev_b = sh_en_b;
    end

    // ---------------- checking ------------------------------------------
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Reference rule: parity error when the count of ones over data and
    // parity bit does not have the configured parity.
    function automatic logic exp_perr(input logic [7:0] d, input logic pbit, input bit pen);
        if (!pen) return 1'b0;
        return ((($countones(d) + int'(pbit)) % 2) != 0);
    endfunction

    // ---------------- stimulus helpers ----------------------------------
    task automatic drive(input bit inst, input logic v, input int nticks);
        if (inst) rx_b = v;
        else      rx_a = v;
        repeat (nticks * tick_div) @(posedge clk);
        #1;
    endtask

    // Drives start, data (LSB first), parity (instance A only) and a stop
    // level held for OS + stop_hold ticks.
    task automatic send_frame(input bit inst, input logic [7:0] d, input logic pbit,
                              input logic stop, input int stop_hold);
        drive(inst, 1'b0, OS);
        // start accepted at mid-bit: flags of the previous frame are cleared
        check("err_clr_on_start", inst ? {perr_b, ferr_b} : {perr_a, ferr_a}, 2'b00);
        for (int i = 0; i < W; i++) drive(inst, d[i], OS);
        if (!inst) drive(inst, pbit, OS);
        drive(inst, stop, OS + stop_hold);
    endtask

    task automatic check_frame(input bit inst, input logic [7:0] d, input logic pbit,
                               input logic stop);
        ev_t q[$];
        logic [7:0] got;
        int nld;
        int badgap;
        int pen;
        if (inst) q = q_b;
        else      q = q_a;
        pen = inst ? 0 : 1;
        got = '0;
        nld = 0;
        badgap = 0;
        check("n_strobes", q.size(), W + int'(stop));
        for (int i = 0; i < W && i < q.size(); i++) begin
            got[i] = q[i].b;
            if (q[i].ld) nld++;
            if (i > 0 && (q[i].cyc - q[i-1].cyc) != 32'(OS * tick_div)) badgap++;
        end
        check("data_bits", got, d);
        check("shift_is_not_load", nld, 0);
        check("shift_spacing", badgap, 0);
        if (stop && q.size() == W + 1) begin
            check("load_flags", {q[W].ld, q[W].done}, 2'b11);
            check("load_spacing", q[W].cyc - q[W-1].cyc, 32'((pen + 1) * OS * tick_div));
            check("perr_at_load", q[W].perr, exp_perr(d, pbit, pen != 0));
            check("ferr_at_load", q[W].ferr, 1'b0);
        end
        if (inst) q_b.delete();
        else      q_a.delete();
    endtask

    // Full transaction on one instance, including line recovery
    task automatic run_frame(input bit inst, input logic [7:0] d, input logic pbit,
                             input logic stop, input int hold, input int idle);
        send_frame(inst, d, pbit, stop, stop ? 0 : hold);
        if (!stop) begin
            check("ferr_set", inst ? ferr_b : ferr_a, 1'b1);
            check("busy_in_break", inst ? busy_b : busy_a, 1'b1);
        end
        drive(inst, 1'b1, idle);
        check_frame(inst, d, pbit, stop);
        check("busy_idle", inst ? busy_b : busy_a, 1'b0);
        check("perr_hold", inst ? perr_b : perr_a, exp_perr(d, pbit, !inst));
        check("ferr_hold", inst ? ferr_b : ferr_a, !stop);
    endtask

    // ---------------- main sequence -------------------------------------
    initial begin : g_main
        logic [7:0] d;
        logic       pb;
        logic       st;

        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {sh_en_a, ld_sh_a, rx_bit_a, perr_a, ferr_a, done_a, busy_a}, 7'd0);
        check("reset_b", {sh_en_b, ld_sh_b, rx_bit_b, perr_b, ferr_b, done_b, busy_b}, 7'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Directed frame: line order 1,0,1,0,0,1,0,1 -> 0xA5, even parity 0
        run_frame(1'b0, 8'hA5, 1'b0, 1'b1, 0, 2 * OS);
        // Same frame with wrong parity bit; flag holds into idle
        run_frame(1'b0, 8'hA5, 1'b1, 1'b1, 0, 2 * OS);
        // Next frame clears it once its start bit is accepted
        run_frame(1'b0, 8'h3C, 1'b0, 1'b1, 0, OS);

        // Start glitch: low for 4 ticks only
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, OS / 2);
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy", busy_a, 1'b0);
        check("glitch_no_strobe", q_a.size(), 0);

        // Bad stop, line held low 40 ticks from stop bit start, then good 0x0F
        run_frame(1'b0, 8'h96, 1'b0, 1'b0, 40 - OS, OS);
        run_frame(1'b0, 8'h0F, 1'b0, 1'b1, 0, OS);

        // Reset after the 3rd data strobe
        d = 8'h5A;
        drive(1'b0, 1'b0, OS);
        for (int i = 0; i < 3; i++) drive(1'b0, d[i], OS);
        check("pre_reset_shifts", q_a.size(), 3);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        #2;
        check("async_reset_outs", {sh_en_a, ld_sh_a, rx_bit_a, perr_a, ferr_a, done_a, busy_a}, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.delete();
        drive(1'b0, 1'b1, OS);
        check("no_strobe_after_reset", q_a.size(), 0);
        run_frame(1'b0, 8'hC3, 1'b0, 1'b1, 0, OS);

        // Randomised frames on the parity instance
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            pb = ^d;
            if ($urandom_range(3) == 0) pb = ~pb;
            st = ($urandom_range(6) != 0);
            run_frame(1'b0, d, pb, st, $urandom_range(3 * OS), $urandom_range(2 * OS) + 2);
        end

        // Parity-disabled instance, tick every 4th clk
        tick_div = 4;
        repeat (8) @(posedge clk);
        #1;
        run_frame(1'b1, 8'hA5, 1'b0, 1'b1, 0, OS);
        for (int n = 0; n < 4; n++) begin
            d  = 8'($urandom);
            st = ($urandom_range(4) != 0);
            run_frame(1'b1, d, 1'b0, st, $urandom_range(2 * OS), OS);
        end

        check("strobe_invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
